// File: rtl/alu_ausfuehrungssteuerung_pkg.sv
// Shared definitions for the execute-stage sequencer: state encoding,
// ALU function codes (also used by the ALU decode) and the default watchdog limit.
package alu_ausfuehrungssteuerung_pkg;

  typedef enum logic [2:0] {
    LEER      = 3'd0,
    START     = 3'd1,
    WARTEN    = 3'd2,
    FERTIG    = 3'd3,
    ABKLINGEN = 3'd4
  } zustand_t;

  localparam logic [5:0] FC_ADD  = 6'b000000;
  localparam logic [5:0] FC_SUB  = 6'b000001;
  localparam logic [5:0] FC_AND  = 6'b000010;
  localparam logic [5:0] FC_OR   = 6'b000011;
  localparam logic [5:0] FC_DIV  = 6'b000100;
  localparam logic [5:0] FC_DIVS = 6'b000101;
  localparam logic [5:0] FC_MUL  = 6'b000110;
  localparam logic [5:0] FC_XOR  = 6'b000111;

  // Longest ALU latency (signed divide) is 32 cycles; the limit must exceed it.
  localparam int ZEIT_LIMIT_DEFAULT = 64;

endpackage

// File: rtl/alu_zeitwaechter.sv
// Completion watchdog: clear/enable up-counter that saturates at its terminal
// count, so the expired indication stays asserted until the next clear.
module alu_zeitwaechter
  import alu_ausfuehrungssteuerung_pkg::*;
#(
  parameter int ZeitLimit = ZEIT_LIMIT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic abgelaufen
);

  localparam int zaehler_breite = $clog2(ZeitLimit);
  localparam logic [zaehler_breite-1:0] endwert = zaehler_breite'(ZeitLimit - 1);

  logic [zaehler_breite-1:0] zaehler;

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zaehler <= '0;
    end else if (clear) begin
      zaehler <= '0;
    end else if (enable && !abgelaufen) begin
      zaehler <= zaehler + zaehler_breite'(1);
    end
  end

  assign abgelaufen = (zaehler == endwert);

endmodule

// File: rtl/alu_ausfuehrungssteuerung.sv
// Execute-stage sequencer: accepts an operation from decode, holds operands on
// the ALU, pulses start, captures the result and offers it to writeback.
module alu_ausfuehrungssteuerung
  import alu_ausfuehrungssteuerung_pkg::*;
#(
  parameter int DatenBreite  = 32,
  parameter int RegAdrBreite = 5,
  parameter int ZeitLimit    = ZEIT_LIMIT_DEFAULT
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    AuftragGueltig,
  output logic                    AuftragBereit,
  input  logic [DatenBreite-1:0]  AuftragDaten1,
  input  logic [DatenBreite-1:0]  AuftragDaten2,
  input  logic [5:0]              AuftragFunktionsCode,
  input  logic [RegAdrBreite-1:0] AuftragZielRegister,
  input  logic                    Verwerfen,
  output logic [DatenBreite-1:0]  AluDaten1,
  output logic [DatenBreite-1:0]  AluDaten2,
  output logic [5:0]              AluFunktionsCode,
  output logic                    AluStartSignal,
  input  logic                    AluHatFertigGerechnet,
  input  logic [DatenBreite-1:0]  AluErgebnis,
  output logic                    ErgebnisGueltig,
  input  logic                    ErgebnisBereit,
  output logic [DatenBreite-1:0]  ErgebnisDaten,
  output logic [RegAdrBreite-1:0] ErgebnisZielRegister,
  output logic                    ErgebnisFehler
);

  zustand_t                zustand;
  logic [RegAdrBreite-1:0] auftrag_ziel;
  logic                    annehmen;
  logic                    zeit_abgelaufen;

  alu_zeitwaechter #(.ZeitLimit(ZeitLimit)) u_zeitwaechter (
    .clk       (Clock),
    .rst_n     (Reset),
    .clear     (zustand == START),
    .enable    (zustand == WARTEN || zustand == ABKLINGEN),
    .abgelaufen(zeit_abgelaufen)
  );

  // A flush always blocks acceptance; in FERTIG a new operation only enters
  // when writeback takes the pending result in the same cycle.
  assign AuftragBereit   = !Verwerfen &&
                           (zustand == LEER || (zustand == FERTIG && ErgebnisBereit));
  assign annehmen        = AuftragGueltig && AuftragBereit;
  assign AluStartSignal  = (zustand == START);
  assign ErgebnisGueltig = (zustand == FERTIG);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      // NOTE: data registers are reset as well because they drive outputs that must read 0.
      zustand              <= LEER;
      AluDaten1            <= '0;
      AluDaten2            <= '0;
      AluFunktionsCode     <= '0;
      auftrag_ziel         <= '0;
      ErgebnisDaten        <= '0;
      ErgebnisZielRegister <= '0;
      ErgebnisFehler       <= 1'b0;
    end else begin
      if (annehmen) begin
        AluDaten1        <= AuftragDaten1;
        AluDaten2        <= AuftragDaten2;
        AluFunktionsCode <= AuftragFunktionsCode;
        auftrag_ziel     <= AuftragZielRegister;
      end

      unique case (zustand)
        LEER: begin
          if (annehmen) zustand <= START;
        end
        // Completion is ignored here: the ALU counter may read 0 before loading.
        START: begin
          zustand <= Verwerfen ? ABKLINGEN : WARTEN;
        end
        WARTEN: begin
          if (Verwerfen) begin
            zustand <= ABKLINGEN;
          end else if (AluHatFertigGerechnet) begin
            ErgebnisDaten        <= AluErgebnis;
            ErgebnisZielRegister <= auftrag_ziel;
            ErgebnisFehler       <= 1'b0;
            zustand              <= FERTIG;
          end else if (zeit_abgelaufen) begin
            ErgebnisDaten        <= '0;
            ErgebnisZielRegister <= auftrag_ziel;
            ErgebnisFehler       <= 1'b1;
            zustand              <= FERTIG;
          end
        end
        FERTIG: begin
          if (annehmen)                        zustand <= START;
          else if (Verwerfen || ErgebnisBereit) zustand <= LEER;
        end
        ABKLINGEN: begin
          if (!Verwerfen && (AluHatFertigGerechnet || zeit_abgelaufen)) zustand <= LEER;
        end
        default: zustand <= LEER;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ausfuehrungssteuerung.sv
// Self-checking bench: behavioural ALU with configurable latency and a
// specification-level reference for results and cycle timing.
`timescale 1ns/1ps
module tb_alu_ausfuehrungssteuerung;
  import alu_ausfuehrungssteuerung_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        auftrag_gueltig = 1'b0;
  logic        auftrag_bereit;
  logic [31:0] auftrag_d1 = '0, auftrag_d2 = '0;
  logic [5:0]  auftrag_fc = '0;
  logic [4:0]  auftrag_ziel = '0;
  logic        verwerfen = 1'b0;
  logic [31:0] alu_d1, alu_d2;
  logic [5:0]  alu_fc;
  logic        alu_start;
  logic        alu_fertig;
  logic [31:0] alu_ergebnis;
  logic        erg_gueltig;
  logic        erg_bereit = 1'b0;
  logic [31:0] erg_daten;
  logic [4:0]  erg_ziel;
  logic        erg_fehler;

  int checks = 0;
  int failures = 0;

  // ALU model configuration, written only by the test sequence
  int alu_n = 1;
  bit alu_nie = 1'b0;
  bit stoer_puls = 1'b0;

  // operands of the operation currently in flight
  logic [31:0] akt_a, akt_b;

  always #5 clk = ~clk;

  alu_ausfuehrungssteuerung dut (
    .Clock(clk), .Reset(rst_n),
    .AuftragGueltig(auftrag_gueltig), .AuftragBereit(auftrag_bereit),
    .AuftragDaten1(auftrag_d1), .AuftragDaten2(auftrag_d2),
    .AuftragFunktionsCode(auftrag_fc), .AuftragZielRegister(auftrag_ziel),
    .Verwerfen(verwerfen),
    .AluDaten1(alu_d1), .AluDaten2(alu_d2), .AluFunktionsCode(alu_fc),
    .AluStartSignal(alu_start), .AluHatFertigGerechnet(alu_fertig),
    .AluErgebnis(alu_ergebnis),
    .ErgebnisGueltig(erg_gueltig), .ErgebnisBereit(erg_bereit),
    .ErgebnisDaten(erg_daten), .ErgebnisZielRegister(erg_ziel),
    .ErgebnisFehler(erg_fehler)
  );

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [5:0] fc);
    case (fc)
      FC_ADD:  return a + b;
      FC_SUB:  return a - b;
      FC_AND:  return a & b;
      FC_OR:   return a | b;
      FC_XOR:  return a ^ b;
      FC_MUL:  return a * b;
      FC_DIV:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
      FC_DIVS: return (b == 0) ? 32'hFFFF_FFFF : $unsigned($signed(a) / $signed(b));
      default: return 32'h0;
    endcase
  endfunction

  // Behavioural ALU: loads N at the end of the start cycle, completes in cycle 2+N.
  // Outside the completion cycle its result bus carries garbage.
  initial begin
    int rest;
    logic [31:0] wert;
    rest = -1;
    wert = '0;
    alu_fertig = 1'b0;
    alu_ergebnis = '0;
    forever begin
      @(posedge clk); #1;
      alu_fertig = 1'b0;
      alu_ergebnis = $urandom();
      if (!rst_n) begin
        rest = -1;
      end else if (rest > 0) begin
        rest--;
        if (rest == 0) begin
          alu_fertig = 1'b1;
          alu_ergebnis = wert;
          rest = -1;
        end
      end
      @(negedge clk);
      if (rst_n && alu_start) begin
        wert = alu_ref(alu_d1, alu_d2, alu_fc);
        rest = alu_nie ? -1 : alu_n + 1;
        if (stoer_puls) begin
          alu_fertig = 1'b1;
          alu_ergebnis = 32'hDEAD_BEEF;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
    $fatal(1, "global timeout");
  end

  // Offers one operation; returns at the negedge of cycle 1 (the start cycle).
  // warte = number of extra cycles before acceptance.
  task automatic sende(input logic [31:0] a, input logic [31:0] b, input logic [5:0] fc,
                       input logic [4:0] ziel, input int n, input bit sofort,
                       input bit mit_bereit, output int warte);
    alu_n = n;
    if (!sofort) begin
      @(posedge clk); #1;
    end
    auftrag_gueltig = 1'b1;
    auftrag_d1 = a; auftrag_d2 = b; auftrag_fc = fc; auftrag_ziel = ziel;
    if (mit_bereit) erg_bereit = 1'b1;
    if (!sofort) @(negedge clk);
    else #1;
    warte = 0;
    while (!auftrag_bereit && warte < 20) begin
      @(negedge clk);
      warte++;
    end
    checks++;
    if (auftrag_bereit !== 1'b1) begin
      failures++;
      $display("FAIL accept_bound: AuftragBereit=%0b after %0d cycles, required 1", auftrag_bereit, warte);
    end
    @(posedge clk); #1;
    auftrag_gueltig = 1'b0;
    erg_bereit = 1'b0;
    auftrag_d1 = $urandom(); auftrag_d2 = $urandom();
    akt_a = a; akt_b = b;
    @(negedge clk);
    checks++;
    if ({alu_start, alu_d1, alu_d2, alu_fc, erg_gueltig} !== {1'b1, a, b, fc, 1'b0}) begin
      failures++;
      $display("FAIL start_cycle: start=%0b d1=%h d2=%h fc=%b gueltig=%0b, required 1 %h %h %b 0",
               alu_start, alu_d1, alu_d2, alu_fc, erg_gueltig, a, b, fc);
    end
  endtask

  // From the negedge of cycle 1, waits for ErgebnisGueltig and checks timing and contents.
  task automatic pruefe(input string name, input int zyklus_erw, input logic [31:0] daten,
                        input logic [4:0] ziel, input logic fehler);
    int k;
    bit stabil;
    k = 1;
    stabil = 1'b1;
    while (!erg_gueltig && k < 200) begin
      @(negedge clk);
      k++;
      if (!erg_gueltig && (alu_start !== 1'b0 || alu_d1 !== akt_a || alu_d2 !== akt_b)) stabil = 1'b0;
    end
    checks++;
    if (k !== zyklus_erw || erg_gueltig !== 1'b1) begin
      failures++;
      $display("FAIL %s_timing: ErgebnisGueltig=%0b in cycle %0d, required 1 in cycle %0d",
               name, erg_gueltig, k, zyklus_erw);
    end
    checks++;
    if ({erg_daten, erg_ziel, erg_fehler} !== {daten, ziel, fehler}) begin
      failures++;
      $display("FAIL %s_result: data=%h ziel=%0d fehler=%0b, required data=%h ziel=%0d fehler=%0b",
               name, erg_daten, erg_ziel, erg_fehler, daten, ziel, fehler);
    end
    checks++;
    if (!stabil) begin
      failures++;
      $display("FAIL %s_alu_inputs: operands/start changed while waiting, required stable with start=0", name);
    end
  endtask

  // Holds back writeback for verz cycles, then accepts; ends at negedge after acceptance.
  task automatic nimm_ab(input string name, input int verz, input logic [31:0] daten);
    for (int i = 0; i < verz; i++) begin
      checks++;
      if ({erg_gueltig, erg_daten, auftrag_bereit} !== {1'b1, daten, 1'b0}) begin
        failures++;
        $display("FAIL %s_hold: gueltig=%0b data=%h bereit=%0b, required 1 %h 0",
                 name, erg_gueltig, erg_daten, auftrag_bereit, daten);
      end
      @(negedge clk);
    end
    erg_bereit = 1'b1;
    @(posedge clk); #1;
    erg_bereit = 1'b0;
    @(negedge clk);
    checks++;
    if ({erg_gueltig, auftrag_bereit} !== 2'b01) begin
      failures++;
      $display("FAIL %s_drain: gueltig=%0b bereit=%0b, required 0 1", name, erg_gueltig, auftrag_bereit);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({auftrag_bereit, alu_start, erg_gueltig, erg_fehler, alu_d1, alu_d2, alu_fc, erg_daten, erg_ziel}
        !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 6'h0, 32'h0, 5'h0}) begin
      failures++;
      $display("FAIL reset_state: bereit=%0b start=%0b gueltig=%0b fehler=%0b d1=%h data=%h, required 1 0 0 0 0 0",
               auftrag_bereit, alu_start, erg_gueltig, erg_fehler, alu_d1, erg_daten);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    int w;
    logic [4:0] z;
    z = 5'($urandom());
    sende(32'd5, 32'd7, FC_ADD, z, 1, 1'b0, 1'b0, w);
    pruefe("add", 4, 32'd12, z, 1'b0);
    nimm_ab("add", 0, 32'd12);
  endtask

  task automatic test_div_backpressure();
    int w;
    logic [31:0] a, b;
    sende(32'd100, 32'd7, FC_DIV, 5'd9, 7, 1'b0, 1'b0, w);
    pruefe("div", 10, 32'd14, 5'd9, 1'b0);
    auftrag_gueltig = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({erg_gueltig, erg_daten, auftrag_bereit} !== {1'b1, 32'd14, 1'b0}) begin
        failures++;
        $display("FAIL div_hold: gueltig=%0b data=%h bereit=%0b, required 1 %h 0",
                 erg_gueltig, erg_daten, auftrag_bereit, 32'd14);
      end
      @(negedge clk);
    end
    a = $urandom(); b = $urandom();
    sende(a, b, FC_XOR, 5'd3, 2, 1'b1, 1'b1, w);
    checks++;
    if (w !== 0) begin
      failures++;
      $display("FAIL div_same_cycle_accept: accepted after %0d extra cycles, required 0", w);
    end
    pruefe("div_next", 5, a ^ b, 5'd3, 1'b0);
    nimm_ab("div_next", 1, a ^ b);
  endtask

  task automatic test_spurious();
    int w;
    logic [31:0] a, b;
    a = $urandom(); b = $urandom();
    stoer_puls = 1'b1;
    sende(a, b, FC_SUB, 5'd17, 9, 1'b0, 1'b0, w);
    pruefe("spurious", 12, a - b, 5'd17, 1'b0);
    stoer_puls = 1'b0;
    nimm_ab("spurious", 0, a - b);
  endtask

  task automatic test_timeout();
    int w;
    alu_nie = 1'b1;
    sende(32'd1, 32'd2, FC_MUL, 5'd30, 1, 1'b0, 1'b0, w);
    pruefe("timeout", 66, 32'd0, 5'd30, 1'b1);
    alu_nie = 1'b0;
    nimm_ab("timeout", 2, 32'd0);
  endtask

  task automatic test_random();
    int w, n;
    logic [31:0] a, b, erw;
    logic [5:0] fc;
    logic [5:0] codes [8] = '{FC_ADD, FC_SUB, FC_AND, FC_OR, FC_DIV, FC_DIVS, FC_MUL, FC_XOR};
    logic [4:0] z;
    for (int i = 0; i < 10; i++) begin
      fc = codes[$urandom_range(0, 7)];
      a = $urandom();
      b = (fc == FC_DIV || fc == FC_DIVS) ? 32'($urandom_range(1, 1000)) : $urandom();
      n = $urandom_range(1, 33);
      z = 5'($urandom());
      erw = alu_ref(a, b, fc);
      sende(a, b, fc, z, n, 1'b0, 1'b0, w);
      pruefe("random", 3 + n, erw, z, 1'b0);
      nimm_ab("random", $urandom_range(0, 3), erw);
    end
  endtask

  task automatic test_back_to_back();
    int w, n;
    logic [31:0] a, b;
    logic [31:0] erw;
    logic [4:0] z;
    a = $urandom(); b = $urandom(); n = $urandom_range(1, 5); z = 5'($urandom());
    sende(a, b, FC_AND, z, n, 1'b0, 1'b0, w);
    for (int i = 0; i < 4; i++) begin
      erw = a & b;
      pruefe("b2b", 3 + n, erw, z, 1'b0);
      a = $urandom(); b = $urandom(); n = $urandom_range(1, 5); z = 5'($urandom());
      sende(a, b, FC_AND, z, n, 1'b1, 1'b1, w);
      checks++;
      if (w !== 0) begin
        failures++;
        $display("FAIL b2b_throughput: next op accepted %0d cycles late, required 0", w);
      end
    end
    pruefe("b2b", 3 + n, a & b, z, 1'b0);
    nimm_ab("b2b", 0, a & b);
  endtask

  task automatic test_flush();
    int w;
    bit ok;
    sende(32'hFFFF_FF00, 32'd3, FC_DIVS, 5'd11, 32, 1'b0, 1'b0, w);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    verwerfen = 1'b1;
    auftrag_gueltig = 1'b1;
    @(negedge clk);
    checks++;
    if (auftrag_bereit !== 1'b0) begin
      failures++;
      $display("FAIL flush_bereit: AuftragBereit=%0b during Verwerfen, required 0", auftrag_bereit);
    end
    @(posedge clk); #1;
    verwerfen = 1'b0;
    ok = 1'b1;
    for (int k = 6; k <= 34; k++) begin
      @(negedge clk);
      if (auftrag_bereit !== 1'b0 || erg_gueltig !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL flush_drain: bereit or gueltig seen 1 before completion, required both 0");
    end
    @(negedge clk);
    checks++;
    if ({auftrag_bereit, erg_gueltig, alu_start} !== 3'b100) begin
      failures++;
      $display("FAIL flush_leer: bereit=%0b gueltig=%0b start=%0b, required 1 0 0",
               auftrag_bereit, erg_gueltig, alu_start);
    end
    verwerfen = 1'b1;
    #1;
    checks++;
    if (auftrag_bereit !== 1'b0) begin
      failures++;
      $display("FAIL flush_idle_block: AuftragBereit=%0b with Verwerfen in LEER, required 0", auftrag_bereit);
    end
    @(posedge clk); #1;
    verwerfen = 1'b0;
    auftrag_gueltig = 1'b0;
    @(negedge clk);
    checks++;
    if ({alu_start, erg_gueltig} !== 2'b00) begin
      failures++;
      $display("FAIL flush_no_start: start=%0b gueltig=%0b, required 0 0", alu_start, erg_gueltig);
    end
  endtask

  task automatic test_reset_mid();
    int w;
    sende(32'd40, 32'd2, FC_ADD, 5'd21, 20, 1'b0, 1'b0, w);
    repeat (3) @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({auftrag_bereit, alu_start, erg_gueltig, erg_fehler, alu_d1, alu_d2, alu_fc, erg_daten, erg_ziel}
        !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 6'h0, 32'h0, 5'h0}) begin
      failures++;
      $display("FAIL reset_mid: bereit=%0b start=%0b gueltig=%0b d1=%h d2=%h data=%h ziel=%0d, required 1 0 0 0 0 0 0",
               auftrag_bereit, alu_start, erg_gueltig, alu_d1, alu_d2, erg_daten, erg_ziel);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    sende(32'd8, 32'd9, FC_OR, 5'd4, 3, 1'b0, 1'b0, w);
    checks++;
    if (w !== 0) begin
      failures++;
      $display("FAIL reset_first_accept: accepted %0d cycles after release+1, required 0", w);
    end
    pruefe("after_reset", 6, 32'd9, 5'd4, 1'b0);
    nimm_ab("after_reset", 0, 32'd9);
  endtask

  initial begin
    test_reset();
    test_add();
    test_div_backpressure();
    test_spurious();
    test_timeout();
    test_random();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_ausfuehrungssteuerung.md
# alu_ausfuehrungssteuerung

Execute-stage sequencer sitting directly upstream of the ALU. It accepts one operation from decode over a valid/ready handshake and holds the operands stable on the ALU inputs. It issues a single-cycle start pulse, captures the result in the one cycle the ALU signals completion, and presents the result plus destination register to writeback over a second valid/ready handshake. It also provides a completion watchdog and a flush that drains an in-flight ALU operation before accepting new work.

## Interface
Parameters:
- DatenBreite, 32, operand/result width
- RegAdrBreite, 5, destination register index width
- ZeitLimit, 64, max cycles in WARTEN before timeout (must be > 33, the longest ALU latency plus margin)

Ports:
- Clock  in  1  single clock; all state changes on rising edge
- Reset  in  1  asynchronous, active-low; asserted low clears all state immediately
- AuftragGueltig  in  1  decode offers an operation
- AuftragBereit  out  1  block accepts an operation this cycle
- AuftragDaten1, AuftragDaten2  in  DatenBreite  operands
- AuftragFunktionsCode  in  6  ALU function code
- AuftragZielRegister  in  RegAdrBreite  destination register
- Verwerfen  in  1  flush: discard in-flight and pending result
- AluDaten1, AluDaten2  out  DatenBreite  to ALU Daten1/Daten2
- AluFunktionsCode  out  6  to ALU FunktionsCode
- AluStartSignal  out  1  to ALU StartSignal
- AluHatFertigGerechnet  in  1  ALU completion (single-cycle pulse)
- AluErgebnis  in  DatenBreite  ALU result, valid only while completion is high
- ErgebnisGueltig  out  1  result offered to writeback
- ErgebnisBereit  in  1  writeback accepts
- ErgebnisDaten  out  DatenBreite  captured result
- ErgebnisZielRegister  out  RegAdrBreite  destination register of the result
- ErgebnisFehler  out  1  result produced by timeout; ErgebnisDaten is 0

## Operation
- States: LEER, START, WARTEN, FERTIG, ABKLINGEN. Reset state is LEER.
- All outputs reset to 0, except AuftragBereit, which is 1 in LEER.
- LEER:
  - AuftragBereit=1.
  - On AuftragGueltig, latch operands, code and target into the operand registers, then go to START.
- START:
  - AluStartSignal=1, decoded from the state register with no combinational input path.
  - AluHatFertigGerechnet is ignored in this cycle, because the ALU counter can read 0 spuriously.
  - Clear the timer, then go to WARTEN.
- WARTEN:
  - On AluHatFertigGerechnet, capture AluErgebnis into the result register, set Fehler=0, then go to FERTIG.
  - Otherwise increment the timer. When timer==ZeitLimit-1, set result=0 and Fehler=1, then go to FERTIG.
- FERTIG:
  - ErgebnisGueltig=1, and AuftragBereit=ErgebnisBereit.
  - On ErgebnisBereit with AuftragGueltig, latch the new operation and go to START (back-to-back).
  - On ErgebnisBereit alone, go to LEER.
- ABKLINGEN:
  - AuftragBereit=0 and ErgebnisGueltig=0.
  - Wait for AluHatFertigGerechnet or timeout; the result is discarded. Then go to LEER.
- Verwerfen has priority over all transitions:
  - From WARTEN, go to ABKLINGEN. The ALU divider must not be restarted while busy.
  - From START, go to ABKLINGEN. The start pulse has already been issued.
  - From LEER or FERTIG, go to LEER and drop any pending result.
  - From ABKLINGEN, stay in ABKLINGEN.
  - AuftragBereit=0 in any cycle where Verwerfen=1.
- Alu outputs are driven from the operand registers only. They are stable from START until the completion capture edge and change only on acceptance.
- Result and target registers are loaded only on capture or timeout. ErgebnisDaten holds while ErgebnisGueltig=1 && ErgebnisBereit=0.

## Timing
- Handshake edge is the end of cycle 0. START is cycle 1. The ALU loads its cycle count N at the end of cycle 1, and completion occurs in cycle 2+N.
- ErgebnisGueltig rises in cycle 3+N. Example: N=1 (add, logic) gives a result in cycle 4.
- Back-to-back throughput is one operation per N+3 cycles.
- Timeout: with no completion, ErgebnisGueltig rises in cycle ZeitLimit+2, with Fehler=1.
- Reset low mid-operation: outputs drop to reset values asynchronously. After Reset releases, the first acceptance is possible in the next cycle.

## Structure
- Shared package holds:
  - the state enum encoding
  - the ALU function code localparams, shared with the ALU decode
  - the default ZeitLimit
- One natural sub-module, alu_zeitwaechter: a clear/enable timer with a terminal-count output, used in WARTEN and ABKLINGEN.

## Test plan
- Add 5+7 (code 000000), ALU model completion N=1 → ErgebnisGueltig in cycle 4, ErgebnisDaten=12, target echoed, Fehler=0.
- Div 100/7 (code 000100), N=7, ErgebnisBereit held low 3 cycles → data 14 held stable; acceptance of the next operation occurs in the same cycle ErgebnisBereit rises.
- Completion pulse injected in the START cycle, then the real completion at N=9 → the spurious pulse is ignored and the result is captured at cycle 11.
- ALU model never completes, ZeitLimit=64 → ErgebnisGueltig at cycle 66, Fehler=1, data 0.
- Verwerfen in WARTEN of a Div.s (N=32) → ABKLINGEN, AuftragBereit=0 until completion, then LEER; no ErgebnisGueltig pulse.
- Reset low during WARTEN → all outputs 0 and AuftragBereit=1 immediately, with no result emitted.
